// File: rtl/lsu_misalign_seq.sv
// Load/store sequencer ahead of the byte-addressed data memory: aligned accesses pass through,
// misaligned ones are split into byte accesses. Define LSU_MISALIGN_TRAP_EN to fault them instead.
`timescale 1ns/1ps
module lsu_misalign_seq #(
  parameter int unsigned MEM_SIZE = 4096,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              fault,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_SIZE);

  logic            w_req;
  logic            w_illegal;
  logic [2:0]      w_size;
  logic [ADDR_W:0] w_end;
  logic            w_range_err;
  logic            w_misaligned;
  logic            w_fault;

  // Range check is done one bit wider than the address so addr+N cannot wrap.
  always_comb begin
    w_req = req_read | req_write;
    case (funct3[1:0])
      2'b00:   w_size = 3'd1;
      2'b01:   w_size = 3'd2;
      default: w_size = 3'd4;
    endcase
    w_illegal = (req_read & req_write)
              | (req_read & ((funct3 == 3'b011) | (funct3[2:1] == 2'b11)))
              | (req_write & (funct3 > 3'b010));
    w_end        = {1'b0, addr} + {{(ADDR_W-2){1'b0}}, w_size};
    w_range_err  = w_end > MEM_LIMIT;
    w_misaligned = ((w_size == 3'd2) & addr[0])
                 | ((w_size == 3'd4) & (addr[1:0] != 2'b00));
  end

`ifdef LSU_MISALIGN_TRAP_EN

  assign w_fault = w_req & (w_illegal | w_range_err | w_misaligned);

  always_comb begin
    stall      = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    fault      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_funct3 = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (!rst) begin
      if (w_fault) begin
        fault      = 1'b1;
        resp_valid = 1'b1;
      end else if (w_req) begin
        mem_read   = req_read;
        mem_write  = req_write;
        mem_funct3 = funct3;
        mem_addr   = addr;
        mem_wdata  = wdata;
        resp_valid = 1'b1;
        resp_data  = req_read ? mem_rdata : '0;
      end
    end
  end

`else

  typedef enum logic [1:0] {S_IDLE, S_SPLIT, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_asm;
  logic [2:0]        r_funct3;
  logic              r_is_store;
  logic              w_start;
  logic [1:0]        w_last;

  assign w_fault = w_req & (w_illegal | w_range_err);
  assign w_start = (r_state == S_IDLE) & w_req & ~w_fault & w_misaligned;
  assign w_last  = (r_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_funct3   <= '0;
      r_is_store <= 1'b0;
      r_asm      <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_cnt      <= '0;
        r_addr     <= addr;
        r_wdata    <= wdata;
        r_funct3   <= funct3;
        r_is_store <= req_write;
        r_asm      <= '0;
      end else if (r_state == S_SPLIT) begin
        r_cnt <= r_cnt + 2'd1;
        if (!r_is_store) r_asm[{r_cnt, 3'b000} +: 8] <= mem_rdata[7:0];
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    stall      = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    fault      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_funct3 = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_fault) begin
          fault      = 1'b1;
          resp_valid = 1'b1;
        end else if (w_start) begin
          stall  = 1'b1;
          w_next = S_SPLIT;
        end else if (w_req) begin
          mem_read   = req_read;
          mem_write  = req_write;
          mem_funct3 = funct3;
          mem_addr   = addr;
          mem_wdata  = wdata;
          resp_valid = 1'b1;
          resp_data  = req_read ? mem_rdata : '0;
        end
      end
      S_SPLIT: begin
        stall      = 1'b1;
        mem_read   = ~r_is_store;
        mem_write  = r_is_store;
        mem_funct3 = r_is_store ? 3'b000 : 3'b100;
        mem_addr   = r_addr + {{(ADDR_W-2){1'b0}}, r_cnt};
        if (r_is_store) mem_wdata[7:0] = r_wdata[{r_cnt, 3'b000} +: 8];
        if (r_cnt == w_last) w_next = S_DONE;
      end
      S_DONE: begin
        // Request inputs are still held here; returning to IDLE without decoding them avoids a re-issue.
        resp_valid = 1'b1;
        w_next     = S_IDLE;
        if (!r_is_store) begin
          case (r_funct3)
            3'b001:  resp_data = {{16{r_asm[15]}}, r_asm[15:0]};
            3'b101:  resp_data = {16'h0000, r_asm[15:0]};
            default: resp_data = r_asm;
          endcase
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (rst) begin
      stall      = 1'b0;
      resp_valid = 1'b0;
      resp_data  = '0;
      fault      = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_funct3 = '0;
      mem_addr   = '0;
      mem_wdata  = '0;
    end
  end

`endif

endmodule

// File: tb/tb_lsu_misalign_seq.sv
// Self-checking bench for lsu_misalign_seq: directed cases plus randomized accesses against a byte-array model.
`timescale 1ns/1ps
module tb_lsu_misalign_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_read, req_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, resp_valid, fault, mem_read, mem_write;
  logic [31:0] resp_data, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_funct3;

  logic        mem_clear, pre_we;
  logic [11:0] pre_addr;
  logic [7:0]  pre_data;
  logic [7:0]  mem     [0:4095];
  logic [7:0]  ref_mem [0:4095];

  int checks = 0;
  int errors = 0;

  lsu_misalign_seq #(.MEM_SIZE(4096), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .resp_valid(resp_valid), .resp_data(resp_data),
    .fault(fault), .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory environment: combinational read with size/extension, write on the clock edge.
  always_comb begin
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++)
      if ((mem_addr + 32'(k)) < 32'd4096) w[8*k +: 8] = mem[12'(mem_addr + 32'(k))];
    case (mem_funct3)
      3'b000:  mem_rdata = {{24{w[7]}}, w[7:0]};
      3'b001:  mem_rdata = {{16{w[15]}}, w[15:0]};
      3'b100:  mem_rdata = {24'h0, w[7:0]};
      3'b101:  mem_rdata = {16'h0, w[15:0]};
      default: mem_rdata = w;
    endcase
  end

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (mem_write) begin
      for (int k = 0; k < 4; k++)
        if ((k < 1 || (k < 2 && mem_funct3[1:0] == 2'b01) || mem_funct3[1:0] == 2'b10) &&
            (mem_addr + 32'(k)) < 32'd4096)
          mem[12'(mem_addr + 32'(k))] <= mem_wdata[8*k +: 8];
    end
  end

  // ---- reference model ----
  function automatic int unsigned size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit exp_fault(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
    longint unsigned e;
    e = 64'(a) + 64'(size_of(f3));
    if (rd && wr) return 1'b1;
    if (rd && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    if (wr && f3 > 3'd2) return 1'b1;
    return e > 64'd4096;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
    int unsigned n;
    longint unsigned v;
    n = size_of(f3);
    v = 0;
    for (int k = int'(n) - 1; k >= 0; k--) v = v * 256 + 64'(ref_mem[int'(a) + k]);
    if (!f3[2] && n < 4 && v >= (64'd1 << (8*n - 1))) v = v + (64'd1 << 32) - (64'd1 << (8*n));
    return v[31:0];
  endfunction

  task automatic model_store(input logic [31:0] a, input int unsigned n, input logic [31:0] wd);
    for (int k = 0; k < int'(n); k++) ref_mem[int'(a) + k] = 8'(wd >> (8*k));
  endtask

  // ---- checking helpers ----
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag, input int a, input logic [7:0] exp);
    chk(tag, {24'h0, mem[a]}, {24'h0, exp});
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    req_read = rd; req_write = wr; funct3 = f3; addr = a; wdata = wd;
  endtask

  task automatic preload(input int a, input logic [7:0] d);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    pre_we = 1'b1; pre_addr = 12'(a); pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    #1;
    chk(tag, {27'h0, stall, resp_valid, fault, mem_read, mem_write}, 32'h0);
  endtask

  task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    int unsigned n;
    bit flt, mis;
    logic [31:0] exp_rd;
    n = size_of(f3);
    flt = exp_fault(rd, wr, f3, a);
    mis = !flt && (a % n != 0);
    exp_rd = (rd && !flt) ? model_load(a, f3) : 32'h0;
    @(negedge clk);
    drive(rd, wr, f3, a, wd);
    #1;
    if (flt) begin
      chk({tag, ":fault"}, {27'h0, fault, resp_valid, stall, mem_read, mem_write}, 32'h18);
      chk({tag, ":fdata"}, resp_data, 32'h0);
    end else if (!mis) begin
      chk({tag, ":ctl"}, {27'h0, fault, resp_valid, stall, mem_read, mem_write}, {27'h0, 3'b010, rd, wr});
      chk({tag, ":addr"}, mem_addr, a);
      chk({tag, ":f3"}, {29'h0, mem_funct3}, {29'h0, f3});
      chk({tag, ":data"}, resp_data, exp_rd);
      if (wr) begin
        chk({tag, ":wdata"}, mem_wdata, wd);
        model_store(a, n, wd);
      end
    end else begin
      chk({tag, ":start"}, {27'h0, fault, resp_valid, stall, mem_read, mem_write}, 32'h04);
      for (int k = 0; k < int'(n); k++) begin
        @(negedge clk); #1;
        chk({tag, ":split"}, {24'h0, fault, resp_valid, stall, mem_read, mem_write, mem_funct3},
            {24'h0, 3'b001, rd, wr, (wr ? 3'b000 : 3'b100)});
        chk({tag, ":baddr"}, mem_addr, a + 32'(k));
        if (wr) chk({tag, ":bdata"}, {24'h0, mem_wdata[7:0]}, {24'h0, 8'(wd >> (8*k))});
      end
      @(negedge clk); #1;
      chk({tag, ":done"}, {27'h0, fault, resp_valid, stall, mem_read, mem_write}, 32'h08);
      chk({tag, ":ddata"}, resp_data, exp_rd);
      if (wr) model_store(a, n, wd);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic [2:0]  f3;
    logic [31:0] a;
    int unsigned op;
    logic [2:0]  legal_f3 [5];
    legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    rst = 1'b1; mem_clear = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    drive(1'b1, 1'b0, 3'd2, 32'h100, 32'h0);
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    @(negedge clk);
    mem_clear = 1'b0;
    #1;
    chk("rst_ctl", {24'h0, stall, resp_valid, fault, mem_read, mem_write, mem_funct3}, 32'h0);
    chk("rst_data", resp_data, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    rst = 1'b0;
    idle("idle0");

    preload(32'h100, 8'h44); preload(32'h101, 8'h33); preload(32'h102, 8'h22); preload(32'h103, 8'h11);
    access("lw100", 1'b1, 1'b0, 3'd2, 32'h100, 32'h0);
    chk("lw100_val", resp_data, 32'h11223344);

    access("sw101", 1'b0, 1'b1, 3'd2, 32'h101, 32'hAABBCCDD);
    chk_mem("sw101_b0", 32'h101, 8'hDD);
    chk_mem("sw101_b1", 32'h102, 8'hCC);
    chk_mem("sw101_b2", 32'h103, 8'hBB);
    chk_mem("sw101_b3", 32'h104, 8'hAA);
    access("lw104", 1'b1, 1'b0, 3'd2, 32'h104, 32'h0);
    chk("lw104_val", resp_data, 32'h000000AA);

    preload(32'h203, 8'h80); preload(32'h204, 8'hFF);
    access("lh203", 1'b1, 1'b0, 3'd1, 32'h203, 32'h0);
    chk("lh203_val", resp_data, 32'hFFFFFF80);
    access("lhu203", 1'b1, 1'b0, 3'd5, 32'h203, 32'h0);
    chk("lhu203_val", resp_data, 32'h0000FF80);

    preload(32'hFFF, 8'h9C);
    access("lwFFD", 1'b1, 1'b0, 3'd2, 32'hFFD, 32'h0);
    access("lbFFF", 1'b1, 1'b0, 3'd0, 32'hFFF, 32'h0);
    chk("lbFFF_val", resp_data, 32'hFFFFFF9C);
    access("lwFFC", 1'b1, 1'b0, 3'd2, 32'hFFC, 32'h0);
    access("shFFF", 1'b0, 1'b1, 3'd1, 32'hFFF, 32'h1234);
    access("lbwrap", 1'b1, 1'b0, 3'd4, 32'hFFFFFFFF, 32'h0);
    access("rdwr", 1'b1, 1'b1, 3'd2, 32'h40, 32'h0);
    access("ld011", 1'b1, 1'b0, 3'd3, 32'h40, 32'h0);
    access("st100", 1'b0, 1'b1, 3'd4, 32'h40, 32'h55);
    idle("idle1");

    // reset in the middle of a split store: two bytes land, the rest stay untouched
    preload(32'h301, 8'h11); preload(32'h302, 8'h22); preload(32'h303, 8'h5A); preload(32'h304, 8'h6B);
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd2, 32'h301, 32'h01020304);
    #1 chk("mrst_start", {30'h0, stall, mem_write}, 32'h2);
    @(negedge clk); #1 chk("mrst_b0", mem_addr, 32'h301);
    @(negedge clk); #1 chk("mrst_b1", mem_addr, 32'h302);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_ctl", {24'h0, stall, resp_valid, fault, mem_read, mem_write, mem_funct3}, 32'h0);
    chk("mrst_data", resp_data, 32'h0);
    chk("mrst_addr", mem_addr, 32'h0);
    ref_mem[32'h301] = 8'h04; ref_mem[32'h302] = 8'h03;
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    rst = 1'b0;
    idle("mrst_idle");
    chk_mem("mrst_m301", 32'h301, 8'h04);
    chk_mem("mrst_m302", 32'h302, 8'h03);
    chk_mem("mrst_m303", 32'h303, 8'h5A);
    chk_mem("mrst_m304", 32'h304, 8'h6B);

    for (int t = 0; t < 120; t++) begin
      f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : legal_f3[$urandom_range(0, 4)];
      a  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(4088, 4095)) : 32'($urandom_range(0, 4095));
      op = $urandom_range(0, 9);
      if (op == 0)     access("rnd_rw", 1'b1, 1'b1, f3, a, $urandom);
      else if (op < 6) access("rnd_ld", 1'b1, 1'b0, f3, a, $urandom);
      else             access("rnd_st", 1'b0, 1'b1, f3, a, $urandom);
      if (t % 10 == 9) idle("rnd_idle");
    end
    idle("final_idle");

    bad = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_sweep", 32'(bad), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_misalign_seq.md
Name: lsu_misalign_seq

Overview:
- Load/store sequencer directly upstream of the byte-addressed data memory. Sits between the execute-stage control/ALU outputs and the memory port.
- Aligned accesses pass straight through in the same cycle, so single-cycle timing is preserved.
- Misaligned lh/lhu/lw/sh/sw are split into sequential byte accesses; the core is stalled until they complete.
- Out-of-range and illegal accesses are blocked before reaching memory and flagged as faults.

Parameters:
- MEM_SIZE, 4096, data memory size in bytes; legal addresses are 0..MEM_SIZE-1.
- ADDR_W, 32, width of addr and mem_addr.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_read  in  1  load request from control (mem_read).
- req_write  in  1  store request from control (mem_write).
- funct3  in  3  instruction[14:12] of the load/store.
- addr  in  ADDR_W  effective address (ALU result).
- wdata  in  32  store data (rs2).
- stall  out  1  freeze PC and pipeline while high.
- resp_valid  out  1  load result or store completion is valid this cycle.
- resp_data  out  32  extended load result; 0 for stores and faults.
- fault  out  1  access rejected this cycle.
- mem_read  out  1  read strobe to data memory.
- mem_write  out  1  write strobe to data memory.
- mem_funct3  out  3  access size code to data memory.
- mem_addr  out  ADDR_W  byte address to data memory.
- mem_wdata  out  32  write data to data memory.
- mem_rdata  in  32  combinational read data from data memory.

Behaviour:
- Reset (async, rst=1): state=IDLE, byte counter=0, latched request and assembly register cleared. All outputs are 0.
- Size: N=1 (funct3 000/100), N=2 (001/101), N=4 (010). The access is misaligned when addr mod N != 0.
- Fault conditions, checked in IDLE:
  - req_read and req_write both high.
  - Load funct3 in {011,110,111}.
  - Store funct3 > 010.
  - addr+N > MEM_SIZE (computed in ADDR_W+1 bits, so there is no wrap-around).
- On fault: fault=1 and resp_valid=1 for one combinational cycle. resp_data=0, mem_read=mem_write=0, stall=0, no state change.
- IDLE with no request: all memory strobes 0, resp_valid=0.
- IDLE with an aligned legal request: pass-through in 0 cycles.
  - mem_* = request fields; resp_data=mem_rdata; resp_valid=1; stall=0.
- IDLE with a misaligned legal request:
  - stall=1, no memory access this cycle.
  - Latch addr/wdata/funct3/direction at the clock edge, counter=0, go to SPLIT.
- SPLIT: stall=1. Each cycle issues byte k=counter at mem_addr=latched_addr+k with mem_funct3=000 for stores or 100 for loads.
  - Stores: mem_write=1, mem_wdata[7:0]=wdata byte k.
  - Loads: mem_read=1; mem_rdata[7:0] is captured into assembly byte k at the edge.
  - counter increments each cycle. After k=N-1, go to DONE.
- DONE: stall=0, resp_valid=1, no memory strobes.
  - resp_data = assembly register sign- or zero-extended per latched funct3; 0 for stores.
  - Next state is IDLE. The request inputs in this cycle are ignored, so the same instruction is never re-issued.
- Upstream holds request inputs stable while stall=1. The latched copy is authoritative; input changes in SPLIT/DONE are ignored.
- Latency: aligned 0 cycles. Misaligned takes N+2 cycles total, with stall high for N+1 cycles.
- Reset mid-SPLIT: returns to IDLE immediately. Bytes already written stay written (partial store). No resp_valid is produced.

Optional Feature:
- LSU_MISALIGN_TRAP_EN
- Defined: misaligned legal requests are not split. They fault in IDLE like a range error (fault=1, resp_valid=1, resp_data=0, no memory access). The SPLIT/DONE logic and counter are compiled out.
- Undefined: split behaviour as described above.

Test Plan:
- lw at addr=0x100, memory holds 0x11223344 -> same cycle resp_valid=1, resp_data=0x11223344, stall=0, mem_funct3=010.
- sw 0xAABBCCDD at addr=0x101 -> stall high 5 cycles; byte writes at 0x101..0x104 = DD, CC, BB, AA; DONE resp_valid=1; following aligned lw at 0x104 returns 0x000000AA.
- lh at addr=0x203 with bytes [0x203]=0x80, [0x204]=0xFF -> stall 3 cycles, resp_data=0xFFFFFF80. The same access as lhu gives 0x0000FF80.
- lw at addr=0xFFD (MEM_SIZE=4096) -> fault=1, resp_valid=1, resp_data=0, mem_read=0, stall=0. lb at 0xFFF is legal.
- req_read=req_write=1, then load funct3=011 -> fault=1 each cycle, no memory strobes.
- Misaligned sw 0x01020304 at 0x301, rst pulsed after 2 byte writes -> state IDLE, all outputs 0; [0x301]=04, [0x302]=03, [0x303] and [0x304] unchanged.
